// File: rtl/tetris_pixel_gen.sv
// tetris_pixel_gen: pixel source feeding the VGA controller's rgb_8 input.
// Follows the controller's pixel_en/v_sync and fetches the playfield cell for the
// next displayed pixel. The 1-cycle synchronous RAM read is hidden behind the
// 2-cycle pixel period.
// Optional feature: define TETRIS_GRID_LINES_EN to draw GRID_COLOR on cell edges.
module tetris_pixel_gen #(
    parameter int unsigned BOARD_X0     = 240,
    parameter int unsigned BOARD_Y0     = 80,
    parameter int unsigned BORDER_W     = 4,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter logic [7:0]  BG_COLOR     = 8'h00,
    parameter logic [7:0]  BORDER_COLOR = 8'h92,
    parameter logic [7:0]  GRID_COLOR   = 8'h49
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_en,
    input  logic       v_sync,
    input  logic [2:0] cell_data,
    output logic       cell_rd,
    output logic [7:0] cell_addr,
    output logic [7:0] rgb_8,
    output logic       frame_start,
    output logic       underrun
);

    localparam int unsigned CW      = 10;
    localparam int unsigned BOARD_W = 160;
    localparam int unsigned BOARD_H = 320;

    localparam logic [CW-1:0] X0     = CW'(BOARD_X0);
    localparam logic [CW-1:0] Y0     = CW'(BOARD_Y0);
    localparam logic [CW-1:0] XB0    = CW'(BOARD_X0 - BORDER_W);
    localparam logic [CW-1:0] YB0    = CW'(BOARD_Y0 - BORDER_W);
    localparam logic [CW-1:0] BRD_W  = CW'(BOARD_W + 2 * BORDER_W);
    localparam logic [CW-1:0] BRD_H  = CW'(BOARD_H + 2 * BORDER_W);
    localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {ST_PRIME, ST_WAIT, ST_READY} state_e;
    typedef enum logic [1:0] {PX_BG, PX_BORDER, PX_BOARD, PX_GRID} kind_e;

    state_e        state_q;
    kind_e         kind_q, kind_c;
    logic [CW-1:0] x_q, y_q, x_d, y_d;
    logic [CW-1:0] fx_c, fy_c, bx_c, by_c, ex_c, ey_c;
    logic          vsync_q, vs_fall_c, fetch_c, board_c, grid_c;
    logic [7:0]    rgb_q, addr_c;
    logic          frame_start_q, underrun_q;
    logic [4:0]    row_c;
    logic [3:0]    col_c;
    logic [7:0]    color_c;

    // RGB332 palette for playfield cell values
    function automatic logic [7:0] palette(input logic [2:0] v);
        case (v)
            3'd0:    palette = 8'h00;
            3'd1:    palette = 8'h1F;
            3'd2:    palette = 8'h03;
            3'd3:    palette = 8'hF4;
            3'd4:    palette = 8'hFC;
            3'd5:    palette = 8'h1C;
            3'd6:    palette = 8'h63;
            default: palette = 8'hE0;
        endcase
    endfunction

    // Next coordinates, fetch target selection, region classification and RAM address
    always_comb begin
        x_d       = x_q + 1'b1;
        y_d       = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
        vs_fall_c = vsync_q & ~v_sync;
        fetch_c   = ~vs_fall_c & (pixel_en | (state_q == ST_PRIME));
        fx_c      = pixel_en ? x_d : x_q;
        fy_c      = pixel_en ? y_d : y_q;
        bx_c      = fx_c - X0;
        by_c      = fy_c - Y0;
        ex_c      = fx_c - XB0;
        ey_c      = fy_c - YB0;
        board_c   = (bx_c < CW'(BOARD_W)) && (by_c < CW'(BOARD_H));
`ifdef TETRIS_GRID_LINES_EN
        grid_c    = (bx_c[3:0] == 4'd0) || (by_c[3:0] == 4'd0);
`else
        grid_c    = 1'b0;
`endif
        kind_c    = PX_BG;
        if (board_c)
            kind_c = grid_c ? PX_GRID : PX_BOARD;
        else if ((ex_c < BRD_W) && (ey_c < BRD_H))
            kind_c = PX_BORDER;
        row_c     = by_c[8:4];
        col_c     = bx_c[7:4];
        addr_c    = 8'({row_c, 3'b000}) + 8'({row_c, 1'b0}) + 8'(col_c);
        cell_rd   = rst & fetch_c & board_c;
        cell_addr = cell_rd ? addr_c : 8'h00;
    end

    // Colour of the fetched pixel, resolved when the RAM data is valid
    always_comb begin
        color_c = BG_COLOR;
        case (kind_q)
            PX_BOARD:  color_c = palette(cell_data);
            PX_GRID:   color_c = GRID_COLOR;
            PX_BORDER: color_c = BORDER_COLOR;
            default:   color_c = BG_COLOR;
        endcase
    end

    // Fetch FSM with pixel counters, v_sync edge detect and sticky underrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_PRIME;
            kind_q        <= PX_BG;
            x_q           <= '0;
            y_q           <= '0;
            vsync_q       <= 1'b1;
            rgb_q         <= 8'h00;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            vsync_q       <= v_sync;
            frame_start_q <= vs_fall_c;
            if (vs_fall_c) begin
                x_q        <= '0;
                y_q        <= '0;
                state_q    <= ST_PRIME;
                underrun_q <= 1'b0;
            end else if (pixel_en) begin
                x_q     <= x_d;
                y_q     <= y_d;
                kind_q  <= kind_c;
                state_q <= ST_WAIT;
                if (state_q != ST_READY)
                    underrun_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_PRIME: begin
                        kind_q  <= kind_c;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        rgb_q   <= color_c;
                        state_q <= ST_READY;
                    end
                    default: state_q <= ST_READY;
                endcase
            end
        end
    end

    assign rgb_8       = rgb_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_tetris_pixel_gen.sv
// Bench for tetris_pixel_gen: randomized pixel_en/v_sync against a cycle-timestamp
// reference model of the pixel pipeline, on a reduced screen geometry.
module tb_tetris_pixel_gen;

    localparam int X0 = 4;
    localparam int Y0 = 8;
    localparam int BW = 4;
    localparam int HA = 170;
    localparam int VA = 340;

    logic       clk = 1'b0;
    logic       rst;
    logic       pixel_en;
    logic       v_sync;
    logic [2:0] cell_data = 3'd0;
    logic       cell_rd;
    logic [7:0] cell_addr;
    logic [7:0] rgb_8;
    logic       frame_start;
    logic       underrun;

    tetris_pixel_gen #(
        .BOARD_X0(X0), .BOARD_Y0(Y0), .BORDER_W(BW), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .pixel_en(pixel_en), .v_sync(v_sync),
        .cell_data(cell_data), .cell_rd(cell_rd), .cell_addr(cell_addr),
        .rgb_8(rgb_8), .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Playfield RAM: 1-cycle synchronous read
    logic [2:0] mem [200];
    always @(posedge clk) if (cell_rd && cell_addr < 8'd200) cell_data <= mem[cell_addr];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         mx, my, fx, fy;
    int         cyc_n = 0;
    int         issue_c, prime_c;
    bit         m_under, m_fs, vs_prev;
    logic [7:0] m_rgb;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, x=%0d y=%0d)", tag, got, exp, cyc_n, mx, my);
        end
    endtask

    function automatic bit in_board(input int x, input int y);
        return (x - X0 >= 0) && (x - X0 < 160) && (y - Y0 >= 0) && (y - Y0 < 320);
    endfunction

    function automatic logic [7:0] pal(input logic [2:0] v);
        case (v)
            3'd0: return 8'h00;
            3'd1: return 8'h1F;
            3'd2: return 8'h03;
            3'd3: return 8'hF4;
            3'd4: return 8'hFC;
            3'd5: return 8'h1C;
            3'd6: return 8'h63;
            default: return 8'hE0;
        endcase
    endfunction

    function automatic logic [7:0] pix_color(input int x, input int y);
        int bx, by;
        bx = x - X0;
        by = y - Y0;
        if (in_board(x, y)) begin
`ifdef TETRIS_GRID_LINES_EN
            if (bx % 16 == 0 || by % 16 == 0) return 8'h49;
`endif
            return pal(mem[(by / 16) * 10 + bx / 16]);
        end
        if (bx >= -BW && bx < 160 + BW && by >= -BW && by < 320 + BW) return 8'h92;
        return 8'h00;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; fx = 0; fy = 0;
        m_under = 1'b0; m_fs = 1'b0; m_rgb = 8'h00; vs_prev = 1'b1;
        prime_c = cyc_n; issue_c = cyc_n;
    endtask

    // One pixel clock: drive, compare, advance the model, move to next cycle
    task automatic tick(input logic pe, input logic vs);
        bit vf, fetch, rd;
        int nx, ny;
        logic [7:0] nrgb;
        pixel_en = pe;
        v_sync   = vs;
        #2;
        check_val("rgb_8", 32'(rgb_8), 32'(m_rgb));
        check_val("underrun", 32'(underrun), 32'(m_under));
        check_val("frame_start", 32'(frame_start), 32'(m_fs));
        vf    = vs_prev && !vs;
        fetch = 1'b0;
        nx    = mx;
        ny    = my;
        if (!vf) begin
            if (pe) begin
                fetch = 1'b1;
                if (mx == HA - 1) begin
                    nx = 0;
                    ny = (my == VA - 1) ? 0 : my + 1;
                end else begin
                    nx = mx + 1;
                end
            end else if (cyc_n == prime_c) begin
                fetch = 1'b1;
            end
        end
        rd = fetch && in_board(nx, ny);
        check_val("cell_rd", 32'(cell_rd), 32'(rd));
        if (rd) check_val("cell_addr", 32'(cell_addr), 32'(((ny - Y0) / 16) * 10 + (nx - X0) / 16));
        nrgb = m_rgb;
        if (!vf && !pe && cyc_n == issue_c + 1) nrgb = pix_color(fx, fy);
        if (vf) begin
            mx = 0; my = 0; fx = 0; fy = 0;
            m_under = 1'b0;
            prime_c = cyc_n + 1;
            issue_c = cyc_n + 1;
        end else if (pe) begin
            if (cyc_n < issue_c + 2) m_under = 1'b1;
            mx = nx; my = ny; fx = nx; fy = ny;
            issue_c = cyc_n;
        end
        m_fs    = vf;
        vs_prev = vs;
        m_rgb   = nrgb;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb_8"}, 32'(rgb_8), 32'h00);
        check_val({tag, "_cell_rd"}, 32'(cell_rd), 32'h0);
        check_val({tag, "_cell_addr"}, 32'(cell_addr), 32'h00);
        check_val({tag, "_frame_start"}, 32'(frame_start), 32'h0);
        check_val({tag, "_underrun"}, 32'(underrun), 32'h0);
    endtask

    // Random strobe spacing: mostly 2 cycles, sometimes back-to-back or 3
    task automatic random_run(input int strobes, input bit allow_vs);
        int gap;
        for (int i = 0; i < strobes; i++) begin
            if (allow_vs && $urandom_range(0, 399) == 0) begin
                tick(1'($urandom_range(0, 1)), 1'b0);
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b1);
            end
            gap = $urandom_range(0, 9);
            gap = (gap == 0) ? 1 : (gap == 9) ? 3 : 2;
            tick(1'b1, 1'b1);
            for (int g = 1; g < gap; g++) tick(1'b0, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 200; i++) mem[i] = 3'($urandom_range(0, 7));
        mem[0]   = 3'd1;
        mem[199] = 3'd7;

        rst = 1'b0; pixel_en = 1'b0; v_sync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        model_reset();

        // First line: background only, legal pixel rate
        for (int i = 0; i < HA; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
        end

        // Race to the bottom of the board at full clock rate, then random rate
        for (int i = 0; i < HA * 310; i++) tick(1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b1);
        random_run(3000, 1'b0);

        // Frame restart clears underrun; v_sync fall together with pixel_en
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        repeat (4) tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        random_run(1800, 1'b1);

        // Asynchronous reset right after a strobe (fetch in flight)
        tick(1'b1, 1'b1);
        rst = 1'b0;
        pixel_en = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b1;
        model_reset();
        random_run(1500, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
